instr_fetch_mem: RTL and testbench
==================================

Name: instr_fetch_mem

Overview:
- Parametrised, synchronous instruction memory for the ARM pipeline's fetch stage; replaces the combinational address-decoded ROM.
- Word-organised storage with a runtime program-load write port.
- Registered read with a valid/ready fetch handshake and a single-entry response buffer, so IF can stall without losing a fetched word.
- Flush input drops an in-flight fetch on branch taken.

Parameters:
- ADDR_W, 32, byte-address width of fetch and load addresses.
- DATA_W, 32, instruction word width.
- DEPTH_WORDS, 64, number of stored words (power of two, ≥2).
- BASE_ADDR, 0, byte address of word 0.
- OOR_INSTR, 32'h0000_0000, word returned for out-of-range fetches (matches legacy default).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, 1, fetch request present.
- req_ready, output, 1, block accepts request this cycle.
- req_addr, input, ADDR_W, byte address of instruction (PC).
- flush, input, 1, discard held and in-flight response.
- resp_valid, output, 1, resp_instr/resp_addr valid.
- resp_ready, input, 1, consumer takes response this cycle.
- resp_instr, output, DATA_W, fetched instruction.
- resp_addr, output, ADDR_W, byte address the response belongs to.
- resp_oor, output, 1, request was outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
- ld_en, input, 1, program-load write strobe.
- ld_addr, input, ADDR_W, byte address of word to write.
- ld_data, input, DATA_W, word to write.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: resp_valid=0, resp_instr=0, resp_addr=0, resp_oor=0. req_ready=1 once rst deasserts. Storage contents are not reset.
- Index: idx = (addr - BASE_ADDR) >> 2. Address bits [1:0] are ignored (word-aligned) unless IMEM_ALIGN_CHECK_EN is defined. Out of range when addr < BASE_ADDR or idx ≥ DEPTH_WORDS.
- Handshake:
  - req_ready = !resp_valid || resp_ready (combinational).
  - A request is accepted when req_valid && req_ready && !flush.
  - Latency: exactly 1 cycle. Accept in cycle N gives resp_valid=1 in N+1 with the word for req_addr.
  - Back-to-back accepts sustain one word per cycle while resp_ready=1.
- Hold: while resp_valid && !resp_ready, resp_instr, resp_addr and resp_oor stay stable, and req_ready=0.
- Response drain: when resp_valid && resp_ready and no new accept occurs, resp_valid goes to 0 next cycle.
- Out of range: resp_instr=OOR_INSTR and resp_oor=1. No array access and no wrap-around.
- Load port:
  - When ld_en=1 and the address is in range, mem[idx] <= ld_data at the clock edge.
  - Out-of-range loads are silently ignored.
  - Load and accept to the same index in the same cycle: the response carries ld_data (write-first).
  - Loads are accepted regardless of req/resp state.
- Flush: at the next edge resp_valid=0 and any same-cycle request is not accepted. Flush has priority over resp_ready and req_valid. Data outputs keep their last value.
- Reset mid-operation: pending response is discarded immediately (asynchronous). Storage keeps its contents.

Optional Feature:
- Macro: IMEM_ALIGN_CHECK_EN.
- With the macro defined:
  - Extra output resp_misaligned (1 bit, reset 0).
  - A request with req_addr[1:0] != 0 returns resp_instr=OOR_INSTR and resp_misaligned=1.
  - Misaligned loads are ignored.
- Without the macro: the port is absent and low address bits are ignored.

Decomposition:
- Shared package arm_isa_pkg holds:
  - WORD_BYTES=4 and WORD_SHIFT=2.
  - NOP/OOR encoding constant.
  - Condition-code field position constants for disassembly in benches.
- One sub-module imem_storage_ram: DEPTH_WORDS×DATA_W array with one write port and one synchronous write-first read port.
- Handshake, range check and flush logic stay in the top.

Test Plan:
- Load words 0xE3A00014 to idx0 and 0xE3A01A01 to idx1; request 0 then 4 with resp_ready=1 → resp_valid in cycles N+1 and N+2 with those words and resp_addr 0 and 4.
- Request 0, hold resp_ready=0 for 3 cycles while req_valid=1 → req_ready=0, output stable at 0xE3A00014; release → next word follows one cycle later.
- Request 4*DEPTH_WORDS (256 at defaults) → resp_instr=0x00000000, resp_oor=1; ld_en to 256 leaves idx0 unchanged.
- ld_en to addr 8 with 0xAABBCCDD in the same cycle as a request to 8 → response 0xAABBCCDD.
- Accept request, assert flush the next cycle with resp_ready=0 → resp_valid=0 after that edge; the request presented during flush produces no response.
- Assert rst while resp_valid=1 → resp_valid=0 immediately; after release, request 0 returns the previously loaded word. With IMEM_ALIGN_CHECK_EN defined, request 6 → resp_misaligned=1.

Source files
------------

// File: rtl/arm_isa_pkg.sv
// Shared ARM ISA constants for the fetch-stage instruction memory and its benches.
package arm_isa_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = 2;

    // Legacy ROM returned all-zeros off the end of the program; keep that as the OOR word.
    localparam logic [31:0] IMEM_OOR_INSTR = 32'h0000_0000;
    localparam logic [31:0] ARM_NOP_INSTR  = 32'hE1A0_0000;

    localparam int COND_MSB = 31;
    localparam int COND_LSB = 28;

    function automatic logic [3:0] cond_field(input logic [31:0] instr);
        return instr[COND_MSB:COND_LSB];
    endfunction

endpackage

// File: rtl/imem_storage_ram.sv
// Instruction word array: one write port, one registered write-first read port.
module imem_storage_ram #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= (wr_en_i && (wr_idx_i == rd_idx_i)) ? wr_data_i : mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Fetch-stage instruction memory: 1-cycle registered read, valid/ready handshake, flush, load port.
// Optional IMEM_ALIGN_CHECK_EN adds resp_misaligned_o and rejects misaligned fetches/loads.
module instr_fetch_mem
    import arm_isa_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [DATA_W-1:0] OOR_INSTR   = DATA_W'(IMEM_OOR_INSTR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_instr_o,
    output logic [ADDR_W-1:0] resp_addr_o,
    output logic              resp_oor_o,
`ifdef IMEM_ALIGN_CHECK_EN
    output logic              resp_misaligned_o,
`endif
    input  logic              ld_en_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> WORD_SHIFT) < ADDR_W'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> WORD_SHIFT);
    endfunction

    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic              resp_oor_q, resp_oor_d;
    logic [DATA_W-1:0] rd_data;
    logic              accept, req_in_range, ld_in_range, rd_en, wr_en;
    logic              resp_bad;

    assign req_ready_o  = !resp_valid_q || resp_ready_i;
    assign accept       = req_valid_i && req_ready_o && !flush_i;
    assign req_in_range = in_range(req_addr_i);
    assign ld_in_range  = in_range(ld_addr_i);

`ifdef IMEM_ALIGN_CHECK_EN
    logic req_aligned, ld_aligned, resp_mis_q, resp_mis_d;
    assign req_aligned       = (req_addr_i[1:0] == 2'b00);
    assign ld_aligned        = (ld_addr_i[1:0] == 2'b00);
    assign rd_en             = accept && req_in_range && req_aligned;
    assign wr_en             = ld_en_i && ld_in_range && ld_aligned;
    assign resp_bad          = resp_oor_q || resp_mis_q;
    assign resp_misaligned_o = resp_mis_q;
`else
    assign rd_en    = accept && req_in_range;
    assign wr_en    = ld_en_i && ld_in_range;
    assign resp_bad = resp_oor_q;
`endif

    imem_storage_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_idx_i  (to_idx(ld_addr_i)),
        .wr_data_i (ld_data_i),
        .rd_en_i   (rd_en),
        .rd_idx_i  (to_idx(req_addr_i)),
        .rd_data_o (rd_data)
    );

    // Flush wins over both a new accept and a drain; data registers keep their value.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_addr_d  = resp_addr_q;
        resp_oor_d   = resp_oor_q;
`ifdef IMEM_ALIGN_CHECK_EN
        resp_mis_d   = resp_mis_q;
`endif
        if (flush_i) begin
            resp_valid_d = 1'b0;
        end else if (accept) begin
            resp_valid_d = 1'b1;
            resp_addr_d  = req_addr_i;
            resp_oor_d   = !req_in_range;
`ifdef IMEM_ALIGN_CHECK_EN
            resp_mis_d   = !req_aligned;
`endif
        end else if (resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_oor_q   <= 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
            resp_mis_q   <= 1'b0;
`endif
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_oor_q   <= resp_oor_d;
`ifdef IMEM_ALIGN_CHECK_EN
            resp_mis_q   <= resp_mis_d;
`endif
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_addr_o  = resp_addr_q;
    assign resp_oor_o   = resp_oor_q;
    assign resp_instr_o = resp_bad ? OOR_INSTR : rd_data;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem at default parameters (64 words, base 0).
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [31:0] resp_instr, resp_addr;
    logic        resp_oor;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0, ld_data = '0;
`ifdef IMEM_ALIGN_CHECK_EN
    logic        resp_mis;
`endif

    instr_fetch_mem dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .flush_i      (flush),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_instr_o (resp_instr),
        .resp_addr_o  (resp_addr),
        .resp_oor_o   (resp_oor),
`ifdef IMEM_ALIGN_CHECK_EN
        .resp_misaligned_o (resp_mis),
`endif
        .ld_en_i      (ld_en),
        .ld_addr_i    (ld_addr),
        .ld_data_i    (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        oor;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [64];
    logic        m_valid = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_in_range(input logic [31:0] a);
        return (a >> 2) < 64;
    endfunction

    function automatic bit m_misaligned(input logic [31:0] a);
`ifdef IMEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model runs at negedge, when inputs for the coming edge are stable.
    always @(negedge clk) begin
        exp_t e;
        logic m_ready, m_acc;
        if (rst) begin
            m_valid = 1'b0;
            sb.delete();
            chk("valid_in_rst", resp_valid, 0);
        end else begin
            m_ready = !m_valid || resp_ready;
            m_acc   = req_valid && m_ready && !flush;
            chk("resp_valid", resp_valid, m_valid);
            chk("req_ready", req_ready, m_ready);
            if (m_valid) begin
                chk("sb_size", sb.size(), 1);
                if (sb.size() > 0) begin
                    chk("resp_instr", resp_instr, sb[0].instr);
                    chk("resp_addr", resp_addr, sb[0].addr);
                    chk("resp_oor", resp_oor, sb[0].oor);
`ifdef IMEM_ALIGN_CHECK_EN
                    chk("resp_mis", resp_mis, sb[0].mis);
`endif
                    if (resp_ready || flush) void'(sb.pop_front());
                end
            end
            if (ld_en && m_in_range(ld_addr) && !m_misaligned(ld_addr))
                mem_m[ld_addr[7:2]] = ld_data;
            if (m_acc) begin
                e.addr  = req_addr;
                e.oor   = !m_in_range(req_addr);
                e.mis   = m_misaligned(req_addr);
                e.instr = (e.oor || e.mis) ? 32'h0 : mem_m[req_addr[7:2]];
                sb.push_back(e);
            end
            m_valid = flush ? 1'b0 : m_acc ? 1'b1 : resp_ready ? 1'b0 : m_valid;
        end
    end

    task automatic cyc(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                       input logic le, input logic [31:0] la, input logic [31:0] ld);
        req_valid  = rv;
        req_addr   = ra;
        resp_ready = rr;
        flush      = fl;
        ld_en      = le;
        ld_addr    = la;
        ld_data    = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        #3;
        chk("rst_valid", resp_valid, 0);
        chk("rst_instr", resp_instr, 0);
        chk("rst_addr", resp_addr, 0);
        chk("rst_oor", resp_oor, 0);
`ifdef IMEM_ALIGN_CHECK_EN
        chk("rst_mis", resp_mis, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1);

        for (int i = 0; i < 64; i++) cyc(0, 0, 1, 0, 1, 32'(i * 4), $urandom);
        cyc(0, 0, 1, 0, 1, 0, 32'hE3A0_0014);
        cyc(0, 0, 1, 0, 1, 4, 32'hE3A0_1A01);

        // back-to-back fetch
        cyc(1, 0, 1, 0, 0, 0, 0);
        cyc(1, 4, 1, 0, 0, 0, 0);
        idle(2);

        // stall with request pending, then release
        cyc(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 4, 0, 0, 0, 0, 0);
        cyc(1, 4, 1, 0, 0, 0, 0);
        idle(2);

        // out of range fetch and ignored out-of-range load
        cyc(1, 256, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 256, 32'h1234_5678);
        cyc(1, 0, 1, 0, 0, 0, 0);
        idle(2);

        // write-first collision
        cyc(1, 8, 1, 0, 1, 8, 32'hAABB_CCDD);
        idle(2);

        // flush drops held response and the same-cycle request
        cyc(1, 4, 0, 0, 0, 0, 0);
        cyc(1, 8, 0, 1, 0, 0, 0);
        chk("flush_valid", resp_valid, 0);
        idle(3);

        // asynchronous reset with a pending response
        cyc(1, 4, 0, 0, 0, 0, 0);
        chk("pre_rst_valid", resp_valid, 1);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", resp_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 1, 0, 0, 0, 0);
        idle(2);

        // misaligned fetch and load
        cyc(1, 6, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 6, 32'hDEAD_BEEF);
        cyc(1, 4, 1, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, la;
            int r;
            r = $urandom_range(0, 9);
            a = (r == 0) ? 32'(256 + 4 * $urandom_range(0, 15)) :
                (r == 1) ? 32'($urandom_range(0, 255)) : 32'(4 * $urandom_range(0, 63));
            la = (r == 2) ? 32'(260) : 32'(4 * $urandom_range(0, 63));
            cyc(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0), la, $urandom);
        end

        idle(3);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
